shift_reg_unit: RTL and testbench
=================================

// Module: shift_reg_unit
// PURPOSE
//  Multicycle shift register feeding the datapath's shift instructions (sll/srl/sra/sllv/srlv/srav).
//  Consumes the 5-bit shift amount chosen upstream by the ShiftAmt select (shamt / reg B / mem).
//  Shifts one bit position per clock, so a shift by N takes N cycles.
//  Reports start/busy/done to the control FSM.
// PARAMETERS
//  WIDTH  32  data width of the shift register
//  AMT_W  5   shift-amount width; must satisfy 2**AMT_W >= WIDTH
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high reset
//  load      in   1      capture data_in into the shift register (honoured in IDLE only)
//  start     in   1      begin a shift of amt positions (honoured in IDLE only)
//  op        in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//  amt       in   AMT_W  shift amount from the upstream shift-amount mux
//  data_in   in   WIDTH  operand to load
//  data_out  out  WIDTH  shift register contents (registered)
//  busy      out  1      high while state==SHIFT
//  done      out  1      one-cycle pulse when the result is final
// BEHAVIOUR
//  - Reset (async, active-high): data_out=0, state=IDLE, cnt=0, busy=0, done=0. Takes effect immediately, including mid-shift.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE:
//    - load=1 -> data_out<=data_in at the edge.
//    - start=1 -> latch op, cnt<=amt. amt!=0 -> SHIFT; amt==0 -> DONE with data unchanged.
//    - load and start in the same cycle: data_in is loaded at that edge; shifting operates on the loaded value from the next edge.
//  - SHIFT: at each edge, shift data_out one position per latched op and decrement cnt.
//    - On the edge where cnt==1, the last shift is applied and state -> DONE.
//  - Shift ops (one bit per step):
//    - SLL: {d[W-2:0],1'b0}
//    - SRL: {1'b0,d[W-1:1]}
//    - SRA: {d[W-1],d[W-1:1]}
//    - ROR: {d[0],d[W-1:1]}
//  - DONE: done=1 for exactly one cycle, busy=0; unconditionally -> IDLE at the next edge.
//  - Latency: start sampled at edge k; done is high in the cycle after edge k+N for N>=1, and after edge k for N=0.
//  - busy=1 during exactly N cycles.
//  - start or load while in SHIFT or DONE is ignored; no queuing.
//  - op and amt are sampled only at the start edge; later changes have no effect.
//  - data_out is stable outside SHIFT. Intermediate values are visible during SHIFT; consumers read only on done.
//  - amt of all ones (31) is legal: SLL/SRL by 31 leaves 1 live bit; SRA by 31 yields all sign bits.
// CONFIGURATION
//  SHIFT_REG_ROTATE_EN
//  - Defined: op=11 performs rotate-right as above.
//  - Undefined: op=11 is a hold.
//    - FSM still runs N SHIFT cycles with the same busy/done timing.
//    - data_out is unchanged.
// TESTING
//  1. reset pulse mid-shift (SLL, amt=20, after 5 cycles) -> data_out=0, busy=0, done=0 immediately; IDLE after release.
//  2. load 0x000000F0, start op=SLL amt=4 -> busy 4 cycles, done pulse, data_out=0x00000F00.
//  3. load 0x80000000, start op=SRA amt=31 -> done after 31 shifts, data_out=0xFFFFFFFF.
//     Repeat with SRL -> 0x00000001.
//  4. load 0x12345678, start op=SRL amt=0 -> done in the next cycle, busy never high, data_out=0x12345678.
//  5. During an SLL amt=8 on 0x1, pulse start and load (data_in=0xDEAD) at cycle 3 -> ignored; result 0x00000100, single done.
//  6. load 0x00000001, op=ROR amt=1 -> 0x80000000 with SHIFT_REG_ROTATE_EN.
//     Without the macro: 0x00000001, done after 1 cycle.

Source files
------------

// File: rtl/shift_reg_unit.sv
// Multicycle shift unit: one bit position per clock, start/busy/done handshake to the control FSM.
// Optional macro SHIFT_REG_ROTATE_EN: op=11 rotates right; when undefined op=11 holds the data.
module shift_reg_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);
    // state | meaning
    // IDLE  | accepts load/start
    // SHIFT | one bit per clock, r_cnt counts down remaining steps
    // DONE  | one-cycle done pulse, result final

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_shifted;

    always_comb begin
        w_shifted = r_data;
        case (r_op)
            OP_SLL:  w_shifted = {r_data[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shifted = {1'b0, r_data[WIDTH-1:1]};
            OP_SRA:  w_shifted = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            default: begin
`ifdef SHIFT_REG_ROTATE_EN
                w_shifted = {r_data[0], r_data[WIDTH-1:1]};
`else
                w_shifted = r_data;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_SLL;
            r_cnt   <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (load)
                        r_data <= data_in;
                    if (start) begin
                        r_op  <= op;
                        r_cnt <= amt;
                        // A zero-length shift goes straight to DONE with the data untouched
                        if (amt != '0) begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data <= w_shifted;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = r_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Bench for shift_reg_unit: vector table of single shifts plus reset, ignored-request and load+start sequences.
// Expected ROR results follow SHIFT_REG_ROTATE_EN as defined for the build.
module tb_shift_reg_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [4:0]  amt = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int n_pass = 0;
    int n_total = 0;

    shift_reg_unit #(.WIDTH(32), .AMT_W(5)) dut (
        .clk(clk), .reset(reset), .load(load), .start(start), .op(op), .amt(amt),
        .data_in(data_in), .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  op;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // load, start, then follow busy/done until the done pulse
    task automatic do_shift(input logic [31:0] d, input logic [1:0] o, input logic [4:0] a,
                            input logic [31:0] exp, input string name);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        load = 1'b1; data_in = d;
        @(negedge clk);
        load = 1'b0; start = 1'b1; op = o; amt = a;
        @(negedge clk);
        start = 1'b0; op = ~o; amt = ~a;
        cycles = 0; busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            cycles++;
            @(negedge clk);
        end
        chk({name, "_latency"}, cycles, {27'd0, a});
        chk({name, "_busy_cycles"}, busy_cnt, {27'd0, a});
        chk({name, "_data"}, data_out, exp);
        @(negedge clk);
        chk({name, "_done_single"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        logic [31:0] ror1, ror8;
`ifdef SHIFT_REG_ROTATE_EN
        ror1 = 32'h8000_0000;
        ror8 = 32'h7812_3456;
`else
        ror1 = 32'h0000_0001;
        ror8 = 32'h1234_5678;
`endif
        vecs[0] = '{32'h0000_00F0, 2'b00, 5'd4,  32'h0000_0F00};
        vecs[1] = '{32'h8000_0000, 2'b10, 5'd31, 32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0000, 2'b01, 5'd31, 32'h0000_0001};
        vecs[3] = '{32'h1234_5678, 2'b01, 5'd0,  32'h1234_5678};
        vecs[4] = '{32'h0000_0001, 2'b11, 5'd1,  ror1};
        vecs[5] = '{32'h0000_0001, 2'b00, 5'd31, 32'h8000_0000};
        vecs[6] = '{32'h7FFF_FFFF, 2'b10, 5'd4,  32'h07FF_FFFF};
        vecs[7] = '{32'hF000_0000, 2'b10, 5'd4,  32'hFF00_0000};
        vecs[8] = '{32'h1234_5678, 2'b11, 5'd8,  ror8};
        vecs[9] = '{32'hA5A5_A5A5, 2'b00, 5'd0,  32'hA5A5_A5A5};

        #12;
        chk("reset_data", data_out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            do_shift(vecs[i].d, vecs[i].op, vecs[i].amt, vecs[i].exp, $sformatf("vec%0d", i));

        // reset mid-shift
        @(negedge clk);
        load = 1'b1; data_in = 32'h0000_0001;
        @(negedge clk);
        load = 1'b0; start = 1'b1; op = 2'b00; amt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midshift_busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_data", data_out, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("postreset_busy", {31'd0, busy}, 32'd0);
        chk("postreset_done", {31'd0, done}, 32'd0);
        do_shift(32'h0000_0005, 2'b00, 5'd1, 32'h0000_000A, "postreset");

        // start/load during SHIFT must be ignored
        @(negedge clk);
        load = 1'b1; data_in = 32'h0000_0001;
        @(negedge clk);
        load = 1'b0; start = 1'b1; op = 2'b00; amt = 5'd8;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0; first_done = -1;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
            if (i == 3) begin
                start = 1'b1; load = 1'b1; data_in = 32'h0000_DEAD; op = 2'b01; amt = 5'd1;
            end else begin
                start = 1'b0; load = 1'b0;
            end
            @(negedge clk);
        end
        chk("ignore_done_count", done_cnt, 32'd1);
        chk("ignore_done_cycle", first_done, 32'd8);
        chk("ignore_data", data_out, 32'h0000_0100);

        // load and start in the same cycle: shift operates on the freshly loaded value
        @(negedge clk);
        load = 1'b1; start = 1'b1; data_in = 32'h0000_0003; op = 2'b00; amt = 5'd2;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        first_done = -1;
        for (int i = 0; i < 10; i++) begin
            if (done && first_done < 0) first_done = i;
            @(negedge clk);
        end
        chk("loadstart_done_cycle", first_done, 32'd2);
        chk("loadstart_data", data_out, 32'h0000_000C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
